// File: rtl/h264_quant_pkg.sv
// Shared tables for the 4x4 luma forward quantiser: multiplication factors,
// coefficient-position classes, and the QP div/mod and rounding-offset lookups.
package h264_quant_pkg;

  typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} qclass_t;

  localparam int MF_W = 14;
  localparam int F_W  = 22;
  localparam int QB_W = 5;

  // Rows are qp%6; columns are class A, B, C.
  localparam logic [MF_W-1:0] MF_TAB [6][3] = '{
    '{14'd13107, 14'd5243, 14'd8066},
    '{14'd11916, 14'd4660, 14'd7490},
    '{14'd10082, 14'd4194, 14'd6554},
    '{14'd9362,  14'd3647, 14'd5825},
    '{14'd8192,  14'd3355, 14'd5243},
    '{14'd7282,  14'd2893, 14'd4559}
  };

  // Reverse zigzag index -> class of its (row,col) position.
  localparam qclass_t IDX_CLASS [16] = '{
    CLS_B, CLS_C, CLS_C, CLS_B, CLS_A, CLS_B, CLS_C, CLS_C,
    CLS_C, CLS_C, CLS_A, CLS_B, CLS_A, CLS_C, CLS_C, CLS_A
  };

  // Returns {qp/6, qp%6}; the loop unrolls into a 52-entry constant table, QP>51 reads entry 51.
  function automatic logic [6:0] qp_divmod(input logic [5:0] qp);
    logic [5:0] q;
    logic [6:0] result;
    q = (qp > 6'd51) ? 6'd51 : qp;
    result = '0;
    for (int i = 0; i < 52; i++) begin
      if (q == 6'(i)) result = {4'(i / 6), 3'(i % 6)};
    end
    return result;
  endfunction

  // Rounding offset 2^qbits/3 (intra) or 2^qbits/6 (inter) for qbits = 15 + div.
  function automatic logic [F_W-1:0] round_f(input logic [3:0] div, input logic intra);
    logic [F_W-1:0] result;
    result = '0;
    for (int d = 0; d < 9; d++) begin
      if (div == 4'(d))
        result = intra ? F_W'((32'd1 << (15 + d)) / 32'd3)
                       : F_W'((32'd1 << (15 + d)) / 32'd6);
    end
    return result;
  endfunction

endpackage

// File: rtl/h264_quant_mf_lut.sv
// Registered lookup of multiplication factor, shift and rounding offset for one
// coefficient; its outputs line up with the first pipeline stage.
module h264_quant_mf_lut
  import h264_quant_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  input  logic [5:0]      qp,
  input  logic            intra,
  input  logic [3:0]      idx,
  output logic [MF_W-1:0] mf,
  output logic [QB_W-1:0] qbits,
  output logic [F_W-1:0]  f
);

  logic [6:0] divmod;
  logic [3:0] qdiv;
  logic [2:0] qmod;
  qclass_t    cls;

  assign divmod = qp_divmod(qp);
  assign qdiv   = divmod[6:3];
  assign qmod   = divmod[2:0];
  assign cls    = IDX_CLASS[idx];

  always_ff @(posedge CLK) begin
    if (reset) begin
      mf    <= '0;
      qbits <= '0;
      f     <= '0;
    end else begin
      mf    <= MF_TAB[qmod][cls];
      qbits <= 5'd15 + {1'b0, qdiv};
      f     <= round_f(qdiv, intra);
    end
  end

endmodule

// File: rtl/h264_quantise.sv
// Forward quantiser for 4x4 luma residual blocks: three-stage pipeline from
// transform coefficient to saturated level, plus a per-block nonzero count.
module h264_quantise
  import h264_quant_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             ENABLE,
  input  logic [IN_W-1:0]  YNIN,
  input  logic [5:0]       QP,
  input  logic             INTRA,
  output logic             VALID,
  output logic [OUT_W-1:0] ZOUT,
  output logic             NZVALID,
  output logic [4:0]       NZCOUNT
);

  localparam int PROD_W = IN_W + MF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [3:0]      idx_reg;
  logic [5:0]      qp_reg;
  logic            intra_reg;
  logic [5:0]      qp_sel;
  logic            intra_sel;

  logic            v1_reg, last1_reg, sign1_reg;
  logic [IN_W-1:0] abs1_reg;
  logic [MF_W-1:0] mf1;
  logic [QB_W-1:0] qbits1;
  logic [F_W-1:0]  f1;

  logic              v2_reg, last2_reg, sign2_reg;
  logic [PROD_W-1:0] prod2_reg;
  logic [QB_W-1:0]   qbits2_reg;
  logic [F_W-1:0]    f2_reg;

  logic [SUM_W-1:0] sum3;
  logic [SUM_W-1:0] shifted3;
  logic [OUT_W-1:0] mag3;
  logic [OUT_W-1:0] z3;
  logic             nz3;
  logic [4:0]       acc_reg;

  // The block's first coefficient must see its own QP/INTRA, not the previous block's.
  assign qp_sel    = (idx_reg == 4'd0) ? QP : qp_reg;
  assign intra_sel = (idx_reg == 4'd0) ? INTRA : intra_reg;

  always_ff @(posedge CLK) begin
    if (reset) begin
      idx_reg   <= '0;
      qp_reg    <= '0;
      intra_reg <= 1'b0;
    end else if (ENABLE) begin
      idx_reg <= idx_reg + 4'd1;
      if (idx_reg == 4'd0) begin
        qp_reg    <= QP;
        intra_reg <= INTRA;
      end
    end
  end

  h264_quant_mf_lut u_mf_lut (
    .CLK   (CLK),
    .reset (reset),
    .qp    (qp_sel),
    .intra (intra_sel),
    .idx   (idx_reg),
    .mf    (mf1),
    .qbits (qbits1),
    .f     (f1)
  );

  // S1: magnitude and sign; -2^(IN_W-1) maps to its exact unsigned magnitude.
  always_ff @(posedge CLK) begin
    if (reset) begin
      v1_reg    <= 1'b0;
      last1_reg <= 1'b0;
      sign1_reg <= 1'b0;
      abs1_reg  <= '0;
    end else begin
      v1_reg    <= ENABLE;
      last1_reg <= (idx_reg == 4'd15);
      sign1_reg <= YNIN[IN_W-1];
      abs1_reg  <= YNIN[IN_W-1] ? (~YNIN + 1'b1) : YNIN;
    end
  end

  // S2: multiply
  always_ff @(posedge CLK) begin
    if (reset) begin
      v2_reg     <= 1'b0;
      last2_reg  <= 1'b0;
      sign2_reg  <= 1'b0;
      prod2_reg  <= '0;
      qbits2_reg <= '0;
      f2_reg     <= '0;
    end else begin
      v2_reg     <= v1_reg;
      last2_reg  <= last1_reg;
      sign2_reg  <= sign1_reg;
      prod2_reg  <= abs1_reg * mf1;
      qbits2_reg <= qbits1;
      f2_reg     <= f1;
    end
  end

  always_comb begin
    sum3     = {1'b0, prod2_reg} + SUM_W'(f2_reg);
    shifted3 = sum3 >> qbits2_reg;
    mag3     = (shifted3 > SUM_W'(SAT_MAX)) ? SAT_MAX : shifted3[OUT_W-1:0];
    z3       = sign2_reg ? (~mag3 + 1'b1) : mag3;
    nz3      = (mag3 != '0);
  end

  // S3: output register and nonzero accumulation
  always_ff @(posedge CLK) begin
    if (reset) begin
      VALID   <= 1'b0;
      ZOUT    <= '0;
      NZVALID <= 1'b0;
      NZCOUNT <= '0;
      acc_reg <= '0;
    end else begin
      VALID   <= v2_reg;
      NZVALID <= v2_reg && last2_reg;
      if (v2_reg) begin
        ZOUT <= z3;
        if (last2_reg) begin
          NZCOUNT <= acc_reg + {4'd0, nz3};
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_reg + {4'd0, nz3};
        end
      end
    end
  end

endmodule
